// File: rtl/truth3_pkg.sv
// Shared types and truth-table constants for the 3-input gate response checker.
package truth3_pkg;

   localparam int unsigned CODE_W    = 3;
   localparam int unsigned NUM_CODES = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } t3_state_t;

   localparam logic [NUM_CODES-1:0] TRUTH_NAND3 = 8'h7F;
   localparam logic [NUM_CODES-1:0] TRUTH_AND3  = 8'h80;
   localparam logic [NUM_CODES-1:0] TRUTH_OR3   = 8'hFE;
   localparam logic [NUM_CODES-1:0] TRUTH_NOR3  = 8'h01;

   // Input code as used to index the truth table: a is the MSB.
   function automatic logic [CODE_W-1:0] code_of(input logic a, input logic b, input logic c);
      return {a, b, c};
   endfunction

endpackage

// File: rtl/truth3_checker_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != {W{1'b1}})) begin
         q_d = q_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/truth3_checker.sv
// Response monitor for 3-input gate DUTs: checks y against TRUTH, tracks coverage and first error.
module truth3_checker
   import truth3_pkg::*;
#(
   parameter logic [7:0]  TRUTH = TRUTH_NAND3,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] sample_cnt,
   output logic [7:0]       cov,
   output logic             first_err_vld,
   output logic [2:0]       first_err_code
);

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_RUN  = 2'(RUN);
   localparam logic [1:0] ST_DONE = 2'(DONE);

   logic [1:0]           state_q,  state_d;
   logic [NUM_CODES-1:0] cov_q,    cov_d;
   logic                 fev_q,    fev_d;
   logic [CODE_W-1:0]    fec_q,    fec_d;
   logic                 busy_q,   busy_d;
   logic                 done_q,   done_d;
   logic                 pass_q,   pass_d;

   logic                 accept_c;
   logic                 mismatch_c;
   logic                 err_zero_c;
   logic [CODE_W-1:0]    code_c;
   logic [ERR_W-1:0]     err_cnt_w;
   logic [ERR_W-1:0]     sample_cnt_w;

   always_comb begin
      code_c     = code_of(a, b, c);
      accept_c   = (state_q == ST_RUN) && in_valid && !start;
      mismatch_c = accept_c && (y != TRUTH[code_c]);

      state_d = state_q;
      cov_d   = cov_q;
      fev_d   = fev_q;
      fec_d   = fec_q;

      if (start) begin
         cov_d = '0;
         fev_d = 1'b0;
         fec_d = '0;
      end else if (accept_c) begin
         cov_d = cov_q | (NUM_CODES'(1) << code_c);
         if (mismatch_c && !fev_q) begin
            fev_d = 1'b1;
            fec_d = code_c;
         end
      end

      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN: begin
            if (start) begin
               state_d = ST_RUN;
            end else if (accept_c && (cov_d == {NUM_CODES{1'b1}})) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: if (start) state_d = ST_RUN;
         default: state_d = start ? ST_RUN : ST_IDLE;
      endcase

      // Error count as it will read after this edge, so pass lands with done.
      err_zero_c = start || ((err_cnt_w == '0) && !mismatch_c);
      busy_d     = (state_d == ST_RUN);
      done_d     = (state_d == ST_DONE);
      pass_d     = done_d && err_zero_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cov_q   <= '0;
         fev_q   <= 1'b0;
         fec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cov_q   <= cov_d;
         fev_q   <= fev_d;
         fec_q   <= fec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   sat_cnt #(.W(ERR_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .clr (start),
      .inc (mismatch_c),
      .q   (err_cnt_w)
   );

   sat_cnt #(.W(ERR_W)) u_sample_cnt (
      .clk (clk),
      .rst (rst),
      .clr (start),
      .inc (accept_c),
      .q   (sample_cnt_w)
   );

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_cnt_w;
   assign sample_cnt     = sample_cnt_w;
   assign cov            = cov_q;
   assign first_err_vld  = fev_q;
   assign first_err_code = fec_q;

endmodule

// File: doc/truth3_checker.md
# truth3_checker

Self-checking response monitor for 3-input combinational gate DUTs: the receiving end of the exhaustive a/b/c stimulus our gate testbenches drive. It samples `{a,b,c}` and the DUT output `y` on each valid cycle and compares `y` against a parameterised 8-entry truth table. It counts mismatches, records the first failing input code, tracks coverage of all 8 input codes, and reports pass/fail once coverage completes. It sits beside the stimulus process in gate benches (nand3, and2, or2, …) and is also synthesisable for on-board self-test.

## Interface
- `TRUTH`, 8'h7F: expected `y` per input code; bit index = `{a,b,c}`; default is NAND3
- `ERR_W`, 8: width of the error and sample counters
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; clears all results and enters RUN
- `in_valid`  in  1  qualifies `a,b,c,y` this cycle
- `a`, `b`, `c`  in  1 each  stimulus applied to the DUT
- `y`  in  1  DUT response
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE (all 8 codes seen)
- `pass`  out  1  `done` and `err_cnt == 0`
- `err_cnt`  out  ERR_W  mismatch count; saturates at all-ones
- `sample_cnt`  out  ERR_W  accepted samples; saturates at all-ones
- `cov`  out  8  bit i set once code i has been sampled
- `first_err_vld`  out  1  a mismatch has been captured
- `first_err_code`  out  3  `{a,b,c}` of the first mismatch

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start`. RUN → DONE when an accepted sample makes `cov` == 8'hFF. DONE → RUN on `start`. Any state → IDLE on `rst`.
- `start` in RUN or DONE restarts: clears counters, `cov`, and first-error registers, then stays in or enters RUN. `start` and `in_valid` in the same cycle: clearing wins and the sample is dropped.
- Accept rule: sample accepted iff state == RUN and `in_valid` and not `start`.
- Per accepted sample with code `k = {a,b,c}`:
  - `sample_cnt` += 1
  - `cov[k]` ← 1
  - if `y != TRUTH[k]`: `err_cnt` += 1; if `!first_err_vld`, latch `first_err_code` ← k and set `first_err_vld`.
- Repeated codes are legal. They count as samples and are checked, but `cov` is unchanged.
- Both counters saturate at 2^ERR_W−1 and never wrap.
- Samples in IDLE and DONE are ignored. No counter or flag changes.
- `in_valid` is never back-pressured. The checker accepts every valid cycle in RUN.

## Timing
- Reset values: state IDLE; `busy`, `done`, `pass`, `first_err_vld` = 0; `err_cnt`, `sample_cnt`, `cov`, `first_err_code` = 0.
- All outputs are registered. Effects of a sample accepted at edge N are visible after edge N.
- `done` and `pass` rise in the same cycle as the final `cov` bit. `pass` is the registered result, not combinational from outputs.
- `busy` rises one cycle after `start` is sampled. Clearing is visible in that same cycle.
- `rst` mid-RUN clears everything at that edge. A coincident `in_valid` is dropped.
- Input setup: `a,b,c,y` are stable at the sampling edge. The bench drives them ≥1 ns before the edge and allows DUT propagation before asserting `in_valid`.

## Structure
- Package `truth3_pkg`:
  - state enum `t3_state_t` {IDLE, RUN, DONE}
  - constants TRUTH_NAND3 = 8'h7F, TRUTH_AND3 = 8'h80, TRUTH_OR3 = 8'hFE, TRUTH_NOR3 = 8'h01
- One sub-module `sat_cnt` (params W; ports `clk`, `rst`, `clr`, `inc`, `q`), instantiated twice for `err_cnt` and `sample_cnt`.
- FSM, coverage register, and first-error capture live in the top.

## Test plan
- Correct NAND3 DUT, `start`, then 8 samples for codes 0..7 → `done`=1, `pass`=1, `err_cnt`=0, `sample_cnt`=8, `cov`=8'hFF.
- Stuck-at-1 DUT (`y`=1 always) → after code 7: `done`=1, `pass`=0, `err_cnt`=1, `first_err_code`=3'b111.
- Codes 0,0,1,1,2 only → `busy`=1, `done`=0, `cov`=8'h07, `sample_cnt`=5.
- ERR_W=2 with an always-inverted DUT, codes 0..7 → `err_cnt`=3 (saturated), `sample_cnt`=3, `done`=1, `first_err_code`=0.
- `rst` after 4 samples, then `start` and a full sweep → all results cleared at reset, then normal pass. `start` coincident with `in_valid` → that sample is not counted.
- Samples in IDLE and after DONE → no change to `cov`, `err_cnt`, or `sample_cnt`.
